// File: rtl/noc_ring_stop.sv
// noc_ring_stop: ring stop merging local injection onto a flit ring, ejecting local flits, transit priority with starvation guard
module noc_ring_stop #(
  parameter int NODE_ID      = 29,
  parameter int INJ_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [15:0] inj_data,
  input  logic        inj_valid,
  output logic        inj_ready,
  output logic [15:0] ej_data,
  output logic        ej_valid,
  input  logic        ej_ready,
  input  logic [15:0] ring_in_data,
  input  logic        ring_in_valid,
  output logic        ring_in_ready,
  output logic [15:0] ring_out_data,
  output logic        ring_out_valid,
  input  logic        ring_out_ready,
  output logic [7:0]  inj_drop_cnt
);
  localparam int AW = $clog2(INJ_DEPTH);
  localparam logic [5:0] NID = 6'(NODE_ID);
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);
  localparam logic [AW:0] DEPTH = (AW+1)'(INJ_DEPTH);
  logic [15:0] mem [INJ_DEPTH];
  logic [AW:0] wp, rp, cnt;
  logic        hold_v, out_v, ej_v;
  logic [15:0] hold_d, out_d, ej_d;
  logic [7:0]  starve_cnt;
  logic        fifo_ne, local_h, out_free, ej_free, starved;
  logic        transit_gnt, inj_gnt, eject_go, hold_leave, push, load;
  assign cnt         = wp - rp;
  assign fifo_ne     = cnt != '0;
  assign inj_ready   = cnt != DEPTH;
  assign local_h     = hold_d[15:10] == NID;
  assign out_free    = !out_v | ring_out_ready;
  assign ej_free     = !ej_v | ej_ready;
  assign starved     = (starve_cnt == LIM) & fifo_ne;
  assign transit_gnt = hold_v & !local_h & out_free & !starved;
  assign inj_gnt     = fifo_ne & out_free & !transit_gnt;
  assign eject_go    = hold_v & local_h & ej_free;
  assign hold_leave  = transit_gnt | eject_go;
  assign ring_in_ready = !hold_v | hold_leave;
  assign push        = inj_valid & inj_ready;
  assign load        = ring_in_valid & ring_in_ready;
  assign ring_out_data  = out_d;
  assign ring_out_valid = out_v;
  assign ej_data        = ej_d;
  assign ej_valid       = ej_v;
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < INJ_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wp[AW-1:0]] <= inj_data;
    end
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wp <= '0;
      rp <= '0;
      hold_v <= 1'b0;
      hold_d <= '0;
      out_v <= 1'b0;
      out_d <= '0;
      ej_v <= 1'b0;
      ej_d <= '0;
      starve_cnt <= '0;
      inj_drop_cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (inj_gnt) rp <= rp + 1'b1;
      if (load) begin
        hold_v <= 1'b1;
        hold_d <= ring_in_data;
      end else if (hold_leave) begin
        hold_v <= 1'b0;
      end
      if (transit_gnt | inj_gnt) begin
        out_v <= 1'b1;
        out_d <= transit_gnt ? hold_d : mem[rp[AW-1:0]];
      end else if (ring_out_ready) begin
        out_v <= 1'b0;
      end
      if (eject_go) begin
        ej_v <= 1'b1;
        ej_d <= hold_d;
      end else if (ej_ready) begin
        ej_v <= 1'b0;
      end
      if (inj_gnt) starve_cnt <= '0;
      else if (fifo_ne & transit_gnt & (starve_cnt != LIM)) starve_cnt <= starve_cnt + 1'b1;
      if (inj_valid & !inj_ready & (inj_drop_cnt != 8'hff)) inj_drop_cnt <= inj_drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_noc_ring_stop.sv
// tb_noc_ring_stop: scoreboard bench covering transit, eject backpressure, injection, starvation, overflow and reset
module tb_noc_ring_stop;
  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [15:0] inj_data = '0;
  logic        inj_valid = 1'b0;
  logic        inj_ready;
  logic [15:0] ej_data;
  logic        ej_valid;
  logic        ej_ready = 1'b1;
  logic [15:0] ring_in_data = '0;
  logic        ring_in_valid = 1'b0;
  logic        ring_in_ready;
  logic [15:0] ring_out_data;
  logic        ring_out_valid;
  logic        ring_out_ready = 1'b1;
  logic [7:0]  inj_drop_cnt;
  int n_pass = 0;
  int n_fail = 0;
  logic [15:0] rq[$];
  logic [15:0] eq[$];

  noc_ring_stop dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .inj_data(inj_data), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .ej_data(ej_data), .ej_valid(ej_valid), .ej_ready(ej_ready),
    .ring_in_data(ring_in_data), .ring_in_valid(ring_in_valid), .ring_in_ready(ring_in_ready),
    .ring_out_data(ring_out_data), .ring_out_valid(ring_out_valid), .ring_out_ready(ring_out_ready),
    .inj_drop_cnt(inj_drop_cnt)
  );

  always #5 ACLK = ~ACLK;

  // Inputs change just after rising edges, so a handshake seen at the falling edge is consumed at the next rising edge.
  always @(negedge ACLK) begin
    if (ARESETn && ring_out_valid && ring_out_ready) begin
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL ring_out_unexpected got=%h expected=none", ring_out_data);
      end else begin
        logic [15:0] e;
        e = rq.pop_front();
        if (ring_out_data !== e) begin
          n_fail++;
          $display("FAIL ring_out_data got=%h expected=%h", ring_out_data, e);
        end else n_pass++;
      end
    end
    if (ARESETn && ej_valid && ej_ready) begin
      if (eq.size() == 0) begin
        n_fail++;
        $display("FAIL ej_unexpected got=%h expected=none", ej_data);
      end else begin
        logic [15:0] e;
        e = eq.pop_front();
        if (ej_data !== e) begin
          n_fail++;
          $display("FAIL ej_data got=%h expected=%h", ej_data, e);
        end else n_pass++;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end else n_pass++;
  endtask

  task automatic test_reset;
    #2;
    if (ring_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b expected=0", ring_out_valid); end else n_pass++;
    if (ej_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ej_valid got=%b expected=0", ej_valid); end else n_pass++;
    if (inj_ready !== 1'b1) begin n_fail++; $display("FAIL rst_inj_ready got=%b expected=1", inj_ready); end else n_pass++;
    if (ring_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ring_in_ready got=%b expected=1", ring_in_ready); end else n_pass++;
    if (inj_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_drop got=%0d expected=0", inj_drop_cnt); end else n_pass++;
    step(2);
    ARESETn = 1'b1;
    step(2);
  endtask

  task automatic test_transit;
    ring_in_data = 16'h7855;
    ring_in_valid = 1'b1;
    rq.push_back(16'h7855);
    step();
    ring_in_valid = 1'b0;
    if (ring_out_valid !== 1'b0) begin n_fail++; $display("FAIL transit_early got=%b expected=0", ring_out_valid); end else n_pass++;
    step();
    if (ring_out_valid !== 1'b1 || ring_out_data !== 16'h7855) begin
      n_fail++;
      $display("FAIL transit_latency got=%b/%h expected=1/7855", ring_out_valid, ring_out_data);
    end else n_pass++;
    if (ej_valid !== 1'b0) begin n_fail++; $display("FAIL transit_no_eject got=%b expected=0", ej_valid); end else n_pass++;
    step(3);
  endtask

  task automatic test_eject_backpressure;
    ej_ready = 1'b0;
    ring_in_data = 16'h7523;
    ring_in_valid = 1'b1;
    eq.push_back(16'h7523);
    step();
    ring_in_data = 16'h7401;
    eq.push_back(16'h7401);
    step();
    ring_in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (ej_valid !== 1'b1 || ej_data !== 16'h7523) begin
        n_fail++;
        $display("FAIL eject_held got=%b/%h expected=1/7523", ej_valid, ej_data);
      end else n_pass++;
      if (ring_in_ready !== 1'b0) begin n_fail++; $display("FAIL eject_ring_in_ready got=%b expected=0", ring_in_ready); end else n_pass++;
      step();
    end
    ej_ready = 1'b1;
    step(4);
    if (eq.size() != 0) begin n_fail++; $display("FAIL eject_drain got=%0d expected=0", eq.size()); end else n_pass++;
  endtask

  task automatic test_injection;
    inj_data = 16'h7923;
    inj_valid = 1'b1;
    rq.push_back(16'h7923);
    step();
    inj_valid = 1'b0;
    step();
    if (ring_out_valid !== 1'b1 || ring_out_data !== 16'h7923) begin
      n_fail++;
      $display("FAIL inject_latency got=%b/%h expected=1/7923", ring_out_valid, ring_out_data);
    end else n_pass++;
    chk("inject_drop", {8'h0, inj_drop_cnt}, 16'h0);
    step(3);
  endtask

  task automatic test_starvation;
    int k = 0;
    int stalls = 0;
    int cyc = 0;
    logic acc;
    for (int i = 0; i < 8; i++) rq.push_back(16'h7800 + 16'(i));
    rq.push_back(16'h7abc);
    for (int i = 8; i < 16; i++) rq.push_back(16'h7800 + 16'(i));
    inj_data = 16'h7abc;
    inj_valid = 1'b1;
    while (k < 16 && cyc < 60) begin
      ring_in_data = 16'h7800 + 16'(k);
      ring_in_valid = 1'b1;
      @(negedge ACLK);
      acc = ring_in_ready;
      if (!acc) stalls++;
      @(posedge ACLK);
      #1;
      inj_valid = 1'b0;
      if (acc) k++;
      cyc++;
    end
    ring_in_valid = 1'b0;
    if (k != 16) begin n_fail++; $display("FAIL starve_timeout got=%0d expected=16", k); end else n_pass++;
    if (stalls != 1) begin n_fail++; $display("FAIL starve_stalls got=%0d expected=1", stalls); end else n_pass++;
    step(4);
    if (rq.size() != 0) begin n_fail++; $display("FAIL starve_drain got=%0d expected=0", rq.size()); end else n_pass++;
  endtask

  task automatic test_overflow;
    ring_out_ready = 1'b0;
    ring_in_data = 16'h7855;
    ring_in_valid = 1'b1;
    rq.push_back(16'h7855);
    step();
    ring_in_valid = 1'b0;
    step(2);
    for (int i = 0; i < 6; i++) begin
      inj_data = 16'h7900 + 16'(i);
      inj_valid = 1'b1;
      if (inj_ready !== (i < 4)) begin
        n_fail++;
        $display("FAIL overflow_inj_ready_%0d got=%b expected=%b", i, inj_ready, (i < 4));
      end else n_pass++;
      if (i < 4) rq.push_back(16'h7900 + 16'(i));
      step();
    end
    inj_valid = 1'b0;
    chk("overflow_frozen", ring_out_data, 16'h7855);
    chk("overflow_drop", {8'h0, inj_drop_cnt}, 16'd2);
    ring_out_ready = 1'b1;
    step(8);
    if (rq.size() != 0) begin n_fail++; $display("FAIL overflow_drain got=%0d expected=0", rq.size()); end else n_pass++;
  endtask

  task automatic test_reset_mid_traffic;
    logic [15:0] seq [3];
    int k = 0;
    seq[0] = 16'h7401;
    seq[1] = 16'h7855;
    seq[2] = 16'h7402;
    ring_out_ready = 1'b0;
    ej_ready = 1'b0;
    inj_data = 16'h7aaa;
    inj_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      ring_in_data = seq[k < 3 ? k : 2];
      ring_in_valid = 1'b1;
      @(negedge ACLK);
      if (ring_in_ready && k < 3) k++;
      @(posedge ACLK);
      #1;
    end
    if (ring_out_valid !== 1'b1 || ej_valid !== 1'b1 || inj_ready !== 1'b0 || ring_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_full got=%b%b%b%b expected=1100", ring_out_valid, ej_valid, inj_ready, ring_in_ready);
    end else n_pass++;
    #2;
    ARESETn = 1'b0;
    #1;
    if (ring_out_valid !== 1'b0 || ej_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_valids got=%b%b expected=00", ring_out_valid, ej_valid);
    end else n_pass++;
    chk("midrst_drop", {8'h0, inj_drop_cnt}, 16'h0);
    if (inj_ready !== 1'b1 || ring_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_readies got=%b%b expected=11", inj_ready, ring_in_ready);
    end else n_pass++;
    rq.delete();
    eq.delete();
    inj_valid = 1'b0;
    ring_in_valid = 1'b0;
    ring_out_ready = 1'b1;
    ej_ready = 1'b1;
    step(2);
    ARESETn = 1'b1;
    step(3);
    if (ring_out_valid !== 1'b0 || ej_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL postrst_idle got=%b%b expected=00", ring_out_valid, ej_valid);
    end else n_pass++;
  endtask

  initial begin
    test_reset;
    test_transit;
    test_eject_backpressure;
    test_injection;
    test_starvation;
    test_overflow;
    test_reset_mid_traffic;
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
